// File: rtl/simple_pkg.sv
// Shared types and the round-robin search used by the load arbiter.
package simple_pkg;

  // Upper bound on requesters the generic search below can handle.
  localparam int MAX_REQ  = 32;
  localparam int MAX_IDXW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic                found;
    logic [MAX_IDXW-1:0] idx;
  } pick_t;

  // First valid index at or after ptr, wrapping modulo n. Walks offsets from
  // the far end down so the smallest offset from ptr is the last to write p.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                    input logic [MAX_IDXW-1:0] ptr,
                                    input int                  n);
    pick_t p;
    int    k;
    p = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= n) k = k - n;
      if (i < n && valid[k[MAX_IDXW-1:0]]) begin
        p.found = 1'b1;
        p.idx   = k[MAX_IDXW-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus index of the winner.
module rr_arbiter import simple_pkg::*; #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [MAX_REQ-1:0]  w_valid_ext;
  logic [MAX_IDXW-1:0] w_ptr_ext;
  pick_t               w_pick;
  logic                w_unused;

  // Widen the request vector to the generic search width.
  always_comb begin
    w_valid_ext        = '0;
    w_valid_ext[N-1:0] = valid;
  end

  assign w_ptr_ext = MAX_IDXW'(ptr);
  assign w_pick    = rr_pick(w_valid_ext, w_ptr_ext, N);
  assign found     = w_pick.found;
  assign idx       = w_pick.idx[IW-1:0];
  // Search never returns an index >= N, so the upper bits are always zero.
  assign w_unused  = ^w_pick.idx;

  // Decode the winning index to a one-hot grant.
  always_comb begin
    grant = '0;
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/simple_load_arb.sv
// Shares the load port of one register among N_REQ requesters: round-robin
// accept, one-cycle registered load pulse, then HOLD_CYCLES quiet cycles.
module simple_load_arb import simple_pkg::*; #(
  parameter  int WIDTH       = 32,
  parameter  int N_REQ       = 4,
  parameter  int HOLD_CYCLES = 2,
  localparam int IW          = $clog2(N_REQ),
  localparam int HCW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic                        clk,
  input  logic                        reset_in,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        load_o,
  output logic [WIDTH-1:0]            data_o,
  output logic [IW-1:0]               owner_o,
  output logic                        busy_o
);

  state_t           r_state;
  logic [IW-1:0]    r_rr_ptr;
  logic [HCW-1:0]   r_hold_cnt;
  logic             r_load;
  logic [WIDTH-1:0] r_data;
  logic [IW-1:0]    r_owner;
  logic             r_busy;

  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_idx;
  logic             w_found;
  logic [IW-1:0]    w_next_ptr;
  logic             w_take;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .valid (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .found (w_found)
  );

  // Accept only while idle; reset masks the grant so nothing is taken and lost.
  assign req_ready  = (r_state == IDLE && !reset_in) ? w_grant : '0;
  assign w_take     = (r_state == IDLE) && w_found;
  // Pointer moves just past the winner, wrapping at N_REQ (not a power of 2).
  assign w_next_ptr = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

  // Control FSM with registered load pulse, data, owner and busy flag.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
      r_load     <= 1'b0;
      r_data     <= '0;
      r_owner    <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_data   <= req_data[w_idx];
            r_owner  <= w_idx;
            r_load   <= 1'b1;
            r_busy   <= 1'b1;
            r_rr_ptr <= w_next_ptr;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_load <= 1'b0;
          if (HOLD_CYCLES == 0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_hold_cnt <= HCW'(HOLD_CYCLES - 1);
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          if (r_hold_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        default: begin
          r_load  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign load_o  = r_load;
  assign data_o  = r_data;
  assign owner_o = r_owner;
  assign busy_o  = r_busy;

endmodule
